// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: md_op encodings, FSM state
// codes, default latencies and small op-class decoders.
// Build option: define MDU_MADD_EN to enable madd/maddu/msub/msubu.
package mdu_const;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Ops that take the multiply latency (accumulate forms only when enabled)
    function automatic logic is_mult_op(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) ||
                 (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    // Ops that take the divide latency
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide datapath for the MDU.
// Result layout is {hi, lo}. Divide returns {remainder, quotient}.
// Build option: MDU_MADD_EN adds the accumulate forms.
module mdu_arith
    import mdu_const::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] dvd_s;
    logic signed [31:0] dvs_s;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] dvs_u;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               ovf;

    // Products, quotients and op select. The divisor is forced to 1 for
    // divide-by-zero and for 0x80000000 / -1: the former result is discarded,
    // and dividing by 1 yields exactly the wrapped overflow answer (q=min, r=0)
    // without ever evaluating the overflowing division.
    always_comb begin
        res         = {hi, lo};
        div_by_zero = 1'b0;
        prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
        prod_u = {32'd0, srcA} * {32'd0, srcB};
        ovf    = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
        dvd_s  = $signed(srcA);
        dvs_s  = ((srcB == 32'd0) || ovf) ? 32'sd1 : $signed(srcB);
        quo_s  = dvd_s / dvs_s;
        rem_s  = dvd_s % dvs_s;
        dvs_u  = (srcB == 32'd0) ? 32'd1 : srcB;
        quo_u  = srcA / dvs_u;
        rem_u  = srcA % dvs_u;
        case (md_op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV: begin
                res         = {rem_s, quo_s};
                div_by_zero = (srcB == 32'd0);
            end
            MD_DIVU: begin
                res         = {rem_u, quo_u};
                div_by_zero = (srcB == 32'd0);
            end
`ifdef MDU_MADD_EN
            MD_MADD:  res = {hi, lo} + prod_s;
            MD_MADDU: res = {hi, lo} + prod_u;
            MD_MSUB:  res = {hi, lo} - prod_s;
            MD_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:  res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the E stage. The result is
// computed at the start edge into temporaries and committed to HI/LO on the
// last busy cycle, so busy only models the architectural latency.
// Build option: MDU_MADD_EN enables accumulate ops (multiply latency).
module mdu_ctrl
    import mdu_const::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic        md_we,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    mdu_state_t      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [31:0]     hi_nxt, lo_nxt;
    logic [31:0]     tmp_hi, tmp_lo, tmp_hi_nxt, tmp_lo_nxt;
    logic            tmp_dz, tmp_dz_nxt;
    logic [63:0]     arith_res;
    logic            arith_dz;

    mdu_arith u_arith (
        .md_op       (md_op),
        .srcA        (srcA),
        .srcB        (srcB),
        .hi          (hi),
        .lo          (lo),
        .res         (arith_res),
        .div_by_zero (arith_dz)
    );

    // Next-state: start wins over md_we; requests during RUN are ignored
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi;
        lo_nxt     = lo;
        tmp_hi_nxt = tmp_hi;
        tmp_lo_nxt = tmp_lo;
        tmp_dz_nxt = tmp_dz;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mult_op(md_op) || is_div_op(md_op)) begin
                        tmp_hi_nxt = arith_res[63:32];
                        tmp_lo_nxt = arith_res[31:0];
                        tmp_dz_nxt = arith_dz;
                        cnt_nxt    = is_div_op(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_nxt  = ST_RUN;
                    end
                end else if (md_we) begin
                    if (md_op == MD_MTHI) hi_nxt = srcA;
                    if (md_op == MD_MTLO) lo_nxt = srcA;
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = ST_IDLE;
                    if (!tmp_dz) begin
                        hi_nxt = tmp_hi;
                        lo_nxt = tmp_lo;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counter and HI/LO registers; async clear discards any operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
            tmp_dz <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            tmp_hi <= tmp_hi_nxt;
            tmp_lo <= tmp_lo_nxt;
            tmp_dz <= tmp_dz_nxt;
        end
    end

    assign busy     = (state == ST_RUN);
    assign md_rdata = (md_op == MD_MFHI) ? hi :
                      (md_op == MD_MFLO) ? lo : 32'd0;

endmodule
